// File: rtl/data_mem_if.sv
// data_mem_if: load/store request channel and response channel between the
// pipeline memory stage (master) and the data memory (slave).
interface data_mem_if;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM answering byte/half/word loads and stores after LATENCY cycles;
// define DMEM_BACK_TO_BACK_EN to let a new request be accepted on the response handshake.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [31:0]           rdata_q;
  logic                  err_q, valid_q;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  err, accept, we, unused_addr;
  logic [3:0]            be;
  logic [31:0]           wd, sh, ld;
  assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];
`ifdef DMEM_BACK_TO_BACK_EN
  assign bus.req_ready = !reset && (state_q == IDLE || (state_q == RESP && bus.resp_ready));
`else
  assign bus.req_ready = !reset && state_q == IDLE;
`endif
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  always_comb begin
    idx    = bus.req_addr[ADDR_WIDTH+1:2];
    off    = bus.req_addr[1:0];
    err    = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && off[0])
          || (bus.req_size == 2'b10 && off != 2'b00);
    accept = bus.req_valid && bus.req_ready;
    we     = accept && bus.req_write && !err;
    be     = bus.req_size == 2'b00 ? 4'b0001 << off
           : bus.req_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd     = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}}
           : bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    sh     = mem[idx] >> {off, 3'b000};
    ld     = bus.req_size == 2'b00 ? {{24{bus.req_signed & sh[7]}}, sh[7:0]}
           : bus.req_size == 2'b01 ? {{16{bus.req_signed & sh[15]}}, sh[15:0]} : sh;
  end
  // RAM is never reset; a store commits on its accept edge regardless of later resets
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (we && be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      state_q <= LATENCY > 1 ? WAIT : RESP;
      valid_q <= LATENCY == 1;
      cnt_q   <= CNT_INIT;
      rdata_q <= bus.req_write || err ? '0 : ld;
      err_q   <= err;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_q <= RESP;
        valid_q <= 1'b1;
      end
    end else if (state_q == RESP && bus.resp_ready) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized load/store checks against a byte-array model.
module tb_data_mem_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;
  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a, wd, erd;
    logic        eer;
  } op_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] mb [4*(2**AW)];
  data_mem_if bus();
  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic op_t mk(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, wd, erd, input logic eer);
    return '{w: w, sz: sz, sg: sg, a: a, wd: wd, erd: erd, eer: eer};
  endfunction

  // Byte-level memory: an access touches 2**size consecutive bytes starting at the address.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, wd,
                       output logic [31:0] rd, output logic er);
    int nb, base;
    nb   = 1 << sz;
    base = int'(a) % (4 * (2**AW));
    er   = sz == 2'b11 || (int'(a[1:0]) % nb) != 0;
    rd   = '0;
    if (er) return;
    for (int i = 0; i < nb; i++)
      if (w) mb[base+i] = wd[8*i +: 8];
      else rd[8*i +: 8] = mb[base+i];
    if (!w && sg && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
  endtask

  task automatic xfer(input op_t op, input int bp, output logic [31:0] rd, output logic er,
                      output int lat, output logic [31:0] erd, output logic eer);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = op.w; bus.req_size = op.sz;
    bus.req_signed = op.sg; bus.req_addr = op.a; bus.req_wdata = op.wd; bus.resp_ready = 1'b0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required=1", op.a, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_size = 2'($urandom); bus.req_write = 1'($urandom);
    model(op.w, op.sz, op.sg, op.a, op.wd, erd, eer);
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = bus.resp_rdata; er = bus.resp_err;
    repeat (bp) @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 4;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
    if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_directed(input string name, input op_t ops[$]);
    logic [31:0] rd, erd; logic er, eer; int lat;
    foreach (ops[i]) begin
      xfer(ops[i], 0, rd, er, lat, erd, eer);
      checks += 3;
      if (rd !== ops[i].erd) begin failures++; $display("FAIL %s[%0d] rdata got=%h exp=%h", name, i, rd, ops[i].erd); end
      if (er !== ops[i].eer) begin failures++; $display("FAIL %s[%0d] err got=%b exp=%b", name, i, er, ops[i].eer); end
      if (lat !== LAT) begin failures++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", name, i, lat, LAT); end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h10; bus.resp_ready = 1'b0;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus.resp_valid); end
      if (bus.resp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_rdata[%0d] got=%h exp=deadbeef", i, bus.resp_rdata); end
      if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, bus.req_ready); end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd; logic er, eer; int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h50; bus.req_wdata = 32'h55AA55AA; bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    model(1'b1, 2'b10, 1'b0, 32'h50, 32'h55AA55AA, erd, eer);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid[%0d] got=%b exp=0", i, bus.resp_valid); end
      @(negedge clk);
    end
    bus.resp_ready = 1'b0;
    xfer(mk(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0), 0, rd, er, lat, erd, eer);
    checks += 2;
    if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL midreset_store got=%h exp=55aa55aa", rd); end
    if (lat !== LAT) begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    int t[5]; int cnt = 0, n = 0;
`ifdef DMEM_BACK_TO_BACK_EN
    int gap = LAT;
`else
    int gap = LAT + 1;
`endif
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
    bus.resp_ready = 1'b1;
    while (cnt < 5 && n < 60) begin
      @(negedge clk); n++;
      if (bus.req_ready) begin t[cnt] = cyc; cnt++; end
    end
    @(negedge clk) bus.req_valid = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++;
    if (cnt !== 5) begin failures++; $display("FAIL b2b_accepts got=%0d exp=5", cnt); end
    for (int i = 0; i + 1 < cnt; i++) begin
      checks++;
      if (t[i+1] - t[i] !== gap) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, t[i+1] - t[i], gap); end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd; logic er, eer; int lat;
    op_t op;
    for (int i = 0; i < 64; i++)
      xfer(mk(1'b1, 2'b10, 1'b0, 32'h200 + 32'(4*i), $urandom, 32'h0, 1'b0), 0, rd, er, lat, erd, eer);
    for (int i = 0; i < 150; i++) begin
      op = mk(1'($urandom), 2'($urandom), 1'($urandom), {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 12'h200 + 12'($urandom_range(0, 255))},
              $urandom, 32'h0, 1'b0);
      xfer(op, $urandom_range(0, 2), rd, er, lat, erd, eer);
      checks += 3;
      if (rd !== erd) begin failures++; $display("FAIL rand[%0d] rdata addr=%h got=%h exp=%h", i, op.a, rd, erd); end
      if (er !== eer) begin failures++; $display("FAIL rand[%0d] err addr=%h got=%b exp=%b", i, op.a, er, eer); end
      if (lat !== LAT) begin failures++; $display("FAIL rand[%0d] latency got=%0d exp=%0d", i, lat, LAT); end
    end
  endtask

  initial begin
    op_t q[$];
    foreach (mb[i]) mb[i] = 8'h0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    test_reset();
    q = '{mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0), mk(0, 2, 0, 32'h10, 0, 32'hDEADBEEF, 0)};
    test_directed("word", q);
    q = '{mk(1, 2, 0, 32'h20, 0, 0, 0), mk(1, 0, 0, 32'h21, 32'h80, 0, 0),
          mk(0, 0, 1, 32'h21, 0, 32'hFFFFFF80, 0), mk(0, 0, 0, 32'h21, 0, 32'h00000080, 0),
          mk(0, 2, 0, 32'h20, 0, 32'h00008000, 0)};
    test_directed("lanes", q);
    q = '{mk(1, 2, 0, 32'h30, 32'hAAAAAAAA, 0, 0), mk(1, 1, 0, 32'h32, 32'h1234, 0, 0),
          mk(0, 2, 0, 32'h30, 0, 32'h1234AAAA, 0), mk(1, 1, 0, 32'h32, 32'h8001, 0, 0),
          mk(0, 1, 1, 32'h32, 0, 32'hFFFF8001, 0)};
    test_directed("half", q);
    q = '{mk(1, 2, 0, 32'h40, 32'h11223344, 0, 0), mk(0, 2, 0, 32'h41, 0, 0, 1),
          mk(1, 2, 0, 32'h42, 32'hFFFFFFFF, 0, 1), mk(1, 1, 0, 32'h43, 32'hFFFF, 0, 1),
          mk(0, 3, 0, 32'h44, 0, 0, 1), mk(1, 3, 0, 32'h40, 32'h0, 0, 1),
          mk(0, 2, 0, 32'h40, 0, 32'h11223344, 0)};
    test_directed("errors", q);
    test_backpressure();
    test_reset_mid();
    q = '{mk(1, 2, 0, 32'h1000, 32'hCAFEF00D, 0, 0), mk(0, 2, 0, 32'h0, 0, 32'hCAFEF00D, 0)};
    test_directed("wrap", q);
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
